// File: rtl/maxpool_2x2_stage.sv
// maxpool_2x2_stage: 2x2 stride-2 signed max pooling over one feature map.
// Optional build macro MAXP_RELU_EN clamps negative pooled results to zero.
module maxpool_2x2_stage #(
    parameter int SIZE_1           = 12,
    parameter int SIZE_address_pix = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        maxp_en,
    input  logic [SIZE_address_pix-1:0] memstartp,
    input  logic [SIZE_address_pix-1:0] memstartzap,
    input  logic [4:0]                  matrix,
    output logic [SIZE_address_pix-1:0] read_addressp,
    output logic                        re,
    input  logic signed [SIZE_1-1:0]    qp,
    output logic [SIZE_address_pix-1:0] write_addressp,
    output logic                        we,
    output logic signed [SIZE_1-1:0]    dp,
    output logic                        STOP
);

    localparam int AW = SIZE_address_pix;

    typedef enum logic [2:0] {
        S_IDLE,
        S_R0,
        S_R1,
        S_R2,
        S_R3,
        S_C,
        S_W,
        S_DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [3:0] r_q;
    logic [3:0] r_d;
    logic [3:0] c_q;
    logic [3:0] c_d;

    logic signed [SIZE_1-1:0] max_q;
    logic signed [SIZE_1-1:0] max_d;

    logic [AW-1:0]            raddr_d;
    logic [AW-1:0]            waddr_d;
    logic                     re_d;
    logic                     we_d;
    logic                     stop_d;
    logic signed [SIZE_1-1:0] dp_d;

    logic [3:0]               half;
    logic [3:0]               half_m1;
    logic [AW-1:0]            mat_a;
    logic [AW-1:0]            row_off;
    logic [AW-1:0]            base;
    logic [AW-1:0]            out_addr;
    logic signed [SIZE_1-1:0] cand;
    logic signed [SIZE_1-1:0] pooled;
    logic                     clear;

    // Signed max; a tie keeps the value already held.
    function automatic logic signed [SIZE_1-1:0] smax(
        input logic signed [SIZE_1-1:0] a,
        input logic signed [SIZE_1-1:0] b
    );
        return (b > a) ? b : a;
    endfunction

    assign half    = matrix[4:1];
    assign half_m1 = half - 4'd1;
    assign mat_a   = AW'(matrix);
    assign clear   = rst | ~maxp_en;
    assign cand    = smax(max_q, qp);

    // Window base follows the counters the FSM is moving to, so the
    // first read of a new window is issued on entry to R0.
    assign row_off  = AW'({r_d, 1'b0}) * mat_a;
    assign base     = memstartp + row_off + AW'({c_d, 1'b0});
    assign out_addr = memstartzap + AW'(r_q) * AW'(half) + AW'(c_q);

`ifdef MAXP_RELU_EN
    assign pooled = cand[SIZE_1-1] ? '0 : cand;
`else
    assign pooled = cand;
`endif

    // State register, counters, max accumulator and registered outputs.
    always_ff @(posedge clk) begin
        if (clear) begin
            state_q        <= S_IDLE;
            r_q            <= '0;
            c_q            <= '0;
            max_q          <= '0;
            read_addressp  <= '0;
            write_addressp <= '0;
            re             <= 1'b0;
            we             <= 1'b0;
            dp             <= '0;
            STOP           <= 1'b0;
        end else begin
            state_q        <= state_d;
            r_q            <= r_d;
            c_q            <= c_d;
            max_q          <= max_d;
            read_addressp  <= raddr_d;
            write_addressp <= waddr_d;
            re             <= re_d;
            we             <= we_d;
            dp             <= dp_d;
            STOP           <= stop_d;
        end
    end

    // Next state and window/row counter advance.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        unique case (state_q)
            S_IDLE: begin
                if (maxp_en && !STOP) begin
                    state_d = (half == 4'd0) ? S_DONE : S_R0;
                end
            end
            S_R0: state_d = S_R1;
            S_R1: state_d = S_R2;
            S_R2: state_d = S_R3;
            S_R3: state_d = S_C;
            S_C:  state_d = S_W;
            S_W: begin
                if (c_q == half_m1) begin
                    c_d = '0;
                    r_d = r_q + 4'd1;
                    if (r_q == half_m1) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_R0;
                    end
                end else begin
                    c_d     = c_q + 4'd1;
                    state_d = S_R0;
                end
            end
            S_DONE: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Max accumulation; qp carries the word requested one state earlier.
    always_comb begin
        max_d = max_q;
        unique case (state_q)
            S_R1:             max_d = qp;
            S_R2, S_R3, S_C:  max_d = cand;
            default:          max_d = max_q;
        endcase
    end

    // Outputs are decoded from the state being entered and registered.
    always_comb begin
        re_d    = 1'b0;
        we_d    = 1'b0;
        stop_d  = 1'b0;
        raddr_d = read_addressp;
        waddr_d = write_addressp;
        dp_d    = dp;
        unique case (state_d)
            S_R0: begin
                re_d    = 1'b1;
                raddr_d = base;
            end
            S_R1: begin
                re_d    = 1'b1;
                raddr_d = base + AW'(1);
            end
            S_R2: begin
                re_d    = 1'b1;
                raddr_d = base + mat_a;
            end
            S_R3: begin
                re_d    = 1'b1;
                raddr_d = base + mat_a + AW'(1);
            end
            S_W: begin
                we_d    = 1'b1;
                waddr_d = out_addr;
                dp_d    = pooled;
            end
            S_DONE: stop_d = 1'b1;
            default: stop_d = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_maxpool_2x2_stage.sv
// tb_maxpool_2x2_stage: table-driven passes with a write scoreboard
// plus hand sequences for mid-pass enable drop and reset.
module tb_maxpool_2x2_stage;

    logic               clk;
    logic               rst;
    logic               maxp_en;
    logic [12:0]        memstartp;
    logic [12:0]        memstartzap;
    logic [4:0]         matrix;
    logic [12:0]        read_addressp;
    logic               re;
    logic signed [11:0] qp;
    logic [12:0]        write_addressp;
    logic               we;
    logic signed [11:0] dp;
    logic               STOP;

    maxpool_2x2_stage #(
        .SIZE_1(12),
        .SIZE_address_pix(13)
    ) dut (
        .clk(clk),
        .rst(rst),
        .maxp_en(maxp_en),
        .memstartp(memstartp),
        .memstartzap(memstartzap),
        .matrix(matrix),
        .read_addressp(read_addressp),
        .re(re),
        .qp(qp),
        .write_addressp(write_addressp),
        .we(we),
        .dp(dp),
        .STOP(STOP)
    );

    typedef struct {
        int m;
        int ps;
        int zs;
        int mode;
        int stop;
        int wr;
        int rd;
        int maxoff;
    } vec_t;

    typedef struct {
        logic [12:0] addr;
        int          data;
    } exp_t;

    logic signed [11:0] mem [8192];
    int                 outm [8192];
    exp_t               sbq [$];
    vec_t               tv [8];

    int          checks;
    int          errors;
    int          wr_cnt;
    int          rd_cnt;
    int          max_off;
    logic [12:0] cur_ps;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (re) qp <= mem[read_addressp];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill(input int mode, input int m, input int ps);
        int pat [4];
        pat[0] = -3;
        pat[1] = -7;
        pat[2] = -1;
        pat[3] = -9;
        for (int i = 0; i < m * m; i++) begin
            case (mode)
                0: mem[13'(ps + i)] = 12'(i);
                1: mem[13'(ps + i)] = 12'($urandom_range(0, 4095));
                2: mem[13'(ps + i)] = 12'(pat[i % 4]);
                default: mem[13'(ps + i)] = -12'sd5;
            endcase
        end
    endtask

    task automatic push_expect(input int m, input int ps, input int zs);
        int h;
        int best;
        int v;
        logic [12:0] a;
        exp_t e;
        h = m / 2;
        best = 0;
        for (int r = 0; r < h; r++) begin
            for (int c = 0; c < h; c++) begin
                for (int k = 0; k < 4; k++) begin
                    a = 13'(ps + 2 * r * m + 2 * c + (k / 2) * m + (k % 2));
                    v = int'(mem[a]);
                    if (k == 0 || v > best) best = v;
                end
`ifdef MAXP_RELU_EN
                if (best < 0) best = 0;
`endif
                e.addr = 13'(zs + r * h + c);
                e.data = best;
                sbq.push_back(e);
            end
        end
    endtask

    task automatic sample();
        logic [12:0] d;
        exp_t e;
        if (re) begin
            rd_cnt++;
            d = read_addressp - cur_ps;
            if (int'(d) > max_off) max_off = int'(d);
        end
        if (we) begin
            wr_cnt++;
            outm[write_addressp] = int'(dp);
            if (sbq.size() == 0) begin
                chk("unexpected_write_addr", int'(write_addressp), -1);
            end else begin
                e = sbq.pop_front();
                chk("write_addr", int'(write_addressp), int'(e.addr));
                chk("write_data", int'(dp), e.data);
            end
        end
    endtask

    task automatic start(input int m, input int ps, input int zs);
        matrix      = 5'(m);
        memstartp   = 13'(ps);
        memstartzap = 13'(zs);
        cur_ps      = 13'(ps);
        wr_cnt      = 0;
        rd_cnt      = 0;
        max_off     = -1;
        maxp_en     = 1'b1;
    endtask

    task automatic wait_stop(input int bound, output int stop_cyc);
        stop_cyc = -1;
        for (int k = 1; k <= bound && stop_cyc < 0; k++) begin
            @(negedge clk);
            sample();
            if (STOP) stop_cyc = k;
        end
    endtask

    task automatic run_vec(input vec_t v);
        int sc;
        fill(v.mode, v.m, v.ps);
        push_expect(v.m, v.ps, v.zs);
        start(v.m, v.ps, v.zs);
        wait_stop(v.stop + 20, sc);
        chk("stop_latency", sc, v.stop);
        chk("write_count", wr_cnt, v.wr);
        chk("read_count", rd_cnt, v.rd);
        chk("max_read_offset", max_off, v.maxoff);
        chk("scoreboard_left", sbq.size(), 0);
        repeat (3) begin
            @(negedge clk);
            sample();
        end
        chk("stop_held", int'(STOP), 1);
        chk("we_in_done", int'(we), 0);
        maxp_en = 1'b0;
        @(negedge clk);
        chk("stop_cleared", int'(STOP), 0);
        sbq.delete();
    endtask

    initial begin
        int sc;
        int hit;
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8192; i++) begin
            mem[i]  = '0;
            outm[i] = 0;
        end
        tv[0] = '{4,    0,  100, 0,   25,   4,  16,  15};
        tv[1] = '{5,    0,  200, 0,   25,   4,  16,  18};
        tv[2] = '{2,  300,  400, 2,    7,   1,   4,   3};
        tv[3] = '{1,  500,  600, 0,    1,   0,   0,  -1};
        tv[4] = '{0,  700,  800, 0,    1,   0,   0,  -1};
        tv[5] = '{7, 8180, 8188, 1,   55,   9,  36,  40};
        tv[6] = '{6, 1000, 1100, 3,   55,   9,  36,  35};
        tv[7] = '{31, 2000, 3100, 1, 1351, 225, 900, 928};

        rst         = 1'b1;
        maxp_en     = 1'b0;
        matrix      = '0;
        memstartp   = '0;
        memstartzap = '0;
        cur_ps      = '0;
        repeat (3) @(negedge clk);
        chk("rst_re", int'(re), 0);
        chk("rst_we", int'(we), 0);
        chk("rst_stop", int'(STOP), 0);
        chk("rst_raddr", int'(read_addressp), 0);
        chk("rst_waddr", int'(write_addressp), 0);
        chk("rst_dp", int'(dp), 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            run_vec(tv[i]);
        end

        chk("m4_out0", outm[100], 5);
        chk("m4_out1", outm[101], 7);
        chk("m4_out2", outm[102], 13);
        chk("m4_out3", outm[103], 15);
        chk("m5_out0", outm[200], 6);
        chk("m5_out1", outm[201], 8);
        chk("m5_out2", outm[202], 16);
        chk("m5_out3", outm[203], 18);
`ifdef MAXP_RELU_EN
        chk("m2_relu_out", outm[400], 0);
`else
        chk("m2_neg_out", outm[400], -1);
`endif

        // enable dropped right after the third write, then a fresh pass
        fill(1, 8, 4000);
        push_expect(8, 4000, 5000);
        start(8, 4000, 5000);
        hit = 0;
        for (int k = 0; k < 200 && hit == 0; k++) begin
            @(negedge clk);
            sample();
            if (wr_cnt == 3) hit = 1;
        end
        chk("drop_reached_3rd_write", hit, 1);
        maxp_en = 1'b0;
        @(negedge clk);
        chk("drop_we", int'(we), 0);
        chk("drop_re", int'(re), 0);
        chk("drop_stop", int'(STOP), 0);
        chk("drop_raddr", int'(read_addressp), 0);
        chk("drop_waddr", int'(write_addressp), 0);
        chk("drop_sb_left", sbq.size(), 13);
        sbq.delete();
        push_expect(8, 4000, 5000);
        start(8, 4000, 5000);
        wait_stop(200, sc);
        chk("restart_stop_latency", sc, 97);
        chk("restart_write_count", wr_cnt, 16);
        chk("restart_sb_left", sbq.size(), 0);
        maxp_en = 1'b0;
        @(negedge clk);

        // reset asserted while the third read of a window is issued
        fill(1, 4, 6000);
        push_expect(4, 6000, 6100);
        start(4, 6000, 6100);
        hit = 0;
        for (int k = 0; k < 20 && hit == 0; k++) begin
            @(negedge clk);
            sample();
            if (rd_cnt == 3) hit = 1;
        end
        chk("rst_reached_r2", hit, 1);
        chk("r2_raddr", int'(read_addressp), 6004);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_re", int'(re), 0);
        chk("midrst_we", int'(we), 0);
        chk("midrst_stop", int'(STOP), 0);
        sbq.delete();
        push_expect(4, 6000, 6100);
        wr_cnt  = 0;
        rd_cnt  = 0;
        max_off = -1;
        rst = 1'b0;
        @(negedge clk);
        chk("restart_re", int'(re), 1);
        chk("restart_raddr", int'(read_addressp), 6000);
        sample();
        wait_stop(40, sc);
        chk("rst_restart_stop_latency", sc, 24);
        chk("rst_restart_writes", wr_cnt, 4);
        chk("rst_restart_sb_left", sbq.size(), 0);
        maxp_en = 1'b0;
        @(negedge clk);
        chk("final_stop_cleared", int'(STOP), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/maxpool_2x2_stage.md
Name: maxpool_2x2_stage

Overview:
- Downstream neighbour of the 3x3 convolution stage.
- Once conv raises STOP, reads one finished feature map (matrix x matrix, row-major, signed SIZE_1-bit words) from pixel memory starting at memstartp.
- Applies 2x2 stride-2 max pooling and writes the (matrix/2)x(matrix/2) result row-major from memstartzap.
- Driven by the top-level sequencer with the same enable/STOP handshake as conv.

Parameters:
- SIZE_1, 12, pixel word width (signed).
- SIZE_address_pix, 13, pixel memory address width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- maxp_en  in  1  enable; high for a whole pass, low returns block to idle.
- memstartp  in  SIZE_address_pix  base address of input map.
- memstartzap  in  SIZE_address_pix  base address of output map.
- matrix  in  5  input map side length, 0..31.
- read_addressp  out  SIZE_address_pix  pixel memory read address.
- re  out  1  read enable.
- qp  in  SIZE_1  read data; valid the cycle after re/read_addressp.
- write_addressp  out  SIZE_address_pix  write address.
- we  out  1  write strobe, one cycle per output pixel.
- dp  out  SIZE_1  write data.
- STOP  out  1  pass complete; held until maxp_en falls.

Behaviour:
- Reset (rst=1) and maxp_en=0 have the same effect:
  - state IDLE; re=0, we=0, STOP=0.
  - read_addressp=0, write_addressp=0, dp=0.
  - row counter r=0, column counter c=0, max register=0.
- Derived values: half = matrix>>1 (floor; for odd matrix the last row and column are ignored). Window base = memstartp + (2r)*matrix + 2c. All addresses are modulo 2^SIZE_address_pix (wrap, no error).
- FSM, one state per cycle. All outputs are registered and take the value set in the state they are assigned.
  - IDLE: if maxp_en && !STOP: go to DONE if half==0, else R0.
  - R0: re=1, addr=base.
  - R1: re=1, addr=base+1; max<=qp.
  - R2: re=1, addr=base+matrix; max<=smax(max,qp).
  - R3: re=1, addr=base+matrix+1; max<=smax(max,qp).
  - C: re=0; max<=smax(max,qp).
  - W: we=1, dp=max, write_addressp = memstartzap + r*half + c.
    - Advance: c++. If c==half-1, set c=0 and r++. If r==half-1 and c==half-1, go to DONE; else go to R0.
  - DONE: STOP=1, re=0, we=0. Stay until maxp_en=0.
- smax is a signed comparison; on a tie the existing max is kept.
- we is low in every state except W.
- Latency: 6 cycles per output pixel. STOP rises 6*half*half+1 cycles after the first cycle maxp_en=1 is sampled in IDLE.
- maxp_en falling mid-pass: next edge forces IDLE, counters cleared, we=0. An in-flight write is aborted; no partial write occurs after the deassertion edge.
- rst has priority over maxp_en.
- matrix is sampled every cycle and must be stable for the whole pass. A change mid-pass is undefined.

Optional Feature:
- Macro MAXP_RELU_EN.
- Defined: in W, dp = (max<0) ? 0 : max.
- Not defined: dp = max unmodified, negatives pass through.
- Addressing and timing are identical in both builds.

Test Plan:
- matrix=4, memstartp=0, input 0..15 row-major, memstartzap=100 -> writes 5@100, 7@101, 13@102, 15@103; STOP rises 25 cycles after start.
- matrix=5, input 0..24 -> 4 writes: 6, 8, 16, 18 (last row/col ignored); no read address ≥ memstartp+19.
- matrix=2, input {-3,-7,-1,-9} -> single write dp=-1 without MAXP_RELU_EN; dp=0 with it.
- matrix=1 -> no re, no we; STOP=1 on the cycle after IDLE; STOP held while maxp_en=1, clears on next cycle after maxp_en=0.
- matrix=8, drop maxp_en after the 3rd we, re-raise -> restart from r=c=0, first write again at memstartzap; 16 writes total in the second pass.
- Assert rst during R2 with maxp_en=1 -> next cycle re=0, we=0, STOP=0. After rst release, the pass restarts from memstartp.
